// File: rtl/pulse_extend_mc_if.sv
// Event, mode and status bundle for pulse_extend_mc; ovf_cnt exists only with PULSE_EXT_OVF_CNT_EN.
interface pulse_extend_mc_if #(
    parameter int CH = 4
);
    logic [CH-1:0]   pulse_ina;
    logic [CH-1:0]   retrig;
    logic            ovf_clr;
    logic [CH-1:0]   signal_outa;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   ovf;
`ifdef PULSE_EXT_OVF_CNT_EN
    logic [CH*8-1:0] ovf_cnt;

    modport master (output pulse_ina, retrig, ovf_clr,
                    input  signal_outa, busy, ovf, ovf_cnt);
    modport slave  (input  pulse_ina, retrig, ovf_clr,
                    output signal_outa, busy, ovf, ovf_cnt);
`else
    modport master (output pulse_ina, retrig, ovf_clr,
                    input  signal_outa, busy, ovf);
    modport slave  (input  pulse_ina, retrig, ovf_clr,
                    output signal_outa, busy, ovf);
`endif
endinterface

// File: rtl/pulse_extend_mc.sv
// Multi-channel stretcher: each event -> EXT_CYC high then >= GAP_CYC low; busy channels queue or retrigger.
// Latency: signal_outa rises one clka edge after the event is sampled; busy/ovf share that 1-cycle lag.
// Backpressure: none; events beyond PEND_MAX queued are dropped and flagged in ovf (per-channel drop count with PULSE_EXT_OVF_CNT_EN).
module pulse_extend_mc #(
    parameter int CH       = 4,
    parameter int EXT_CYC  = 5,
    parameter int GAP_CYC  = 2,
    parameter int PEND_MAX = 3
) (
    input  logic              clka,
    input  logic              rst_n,
    pulse_extend_mc_if.slave  io
);
    localparam int MAXC = (EXT_CYC > GAP_CYC) ? EXT_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int PW   = $clog2(PEND_MAX + 1);

    localparam logic [CW-1:0] EXT_LD    = CW'(EXT_CYC - 1);
    localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYC - 1);
    localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

    if (CH < 1 || EXT_CYC < 1 || GAP_CYC < 1 || PEND_MAX < 1) begin : g_bad_param
        $error("pulse_extend_mc: CH, EXT_CYC, GAP_CYC and PEND_MAX must all be >= 1");
    end

    typedef enum logic [1:0] {IDLE, HIGH, GAP} st_t;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        st_t             st;
        logic [CW-1:0]   cnt;
        logic [PW-1:0]   pend;
        logic            ovf_r;
        logic            out_q;
        logic            busy_q;
        logic            ovf_q;
        logic            ev;
        logic            rt;
        logic            full;
        logic            enq;
        logic            drop;
        logic [PW:0]     eff;

        assign ev   = io.pulse_ina[i];
        assign rt   = io.retrig[i];
        assign full = (pend == PEND_FULL);
        // The last GAP cycle dequeues instead of enqueuing, so it can never overflow.
        assign enq  = ev && ((st == HIGH && !rt) || (st == GAP && cnt != '0));
        assign drop = enq && full;
        assign eff  = {1'b0, pend} + {{PW{1'b0}}, ev};

        always_ff @(posedge clka or negedge rst_n) begin
            if (!rst_n) begin
                st     <= IDLE;
                cnt    <= '0;
                pend   <= '0;
                ovf_r  <= 1'b0;
                out_q  <= 1'b0;
                busy_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                out_q  <= (st == HIGH);
                busy_q <= (st != IDLE) || (pend != '0);
                ovf_q  <= ovf_r;

                if (drop)
                    ovf_r <= 1'b1;
                else if (io.ovf_clr)
                    ovf_r <= 1'b0;

                if (enq && !full)
                    pend <= pend + 1'b1;

                case (st)
                    IDLE: begin
                        if (ev) begin
                            st  <= HIGH;
                            cnt <= EXT_LD;
                        end
                    end
                    HIGH: begin
                        if (ev && rt) begin
                            cnt <= EXT_LD;
                        end else if (cnt == '0) begin
                            st  <= GAP;
                            cnt <= GAP_LD;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    GAP: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (eff != '0) begin
                            st   <= HIGH;
                            cnt  <= EXT_LD;
                            pend <= PW'(eff - 1'b1);
                        end else begin
                            st <= IDLE;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end

        assign io.signal_outa[i] = out_q;
        assign io.busy[i]        = busy_q;
        assign io.ovf[i]         = ovf_q;

`ifdef PULSE_EXT_OVF_CNT_EN
        logic [7:0] oc_r;
        logic [7:0] oc_q;

        always_ff @(posedge clka or negedge rst_n) begin
            if (!rst_n) begin
                oc_r <= '0;
                oc_q <= '0;
            end else begin
                oc_q <= oc_r;
                if (drop)
                    oc_r <= io.ovf_clr ? 8'd1 : ((oc_r == 8'hFF) ? oc_r : oc_r + 8'd1);
                else if (io.ovf_clr)
                    oc_r <= '0;
            end
        end

        assign io.ovf_cnt[i*8 +: 8] = oc_q;
`endif
    end
endmodule

// File: tb/tb_pulse_extend_mc.sv
// Table-driven bench for pulse_extend_mc (CH=4, EXT_CYC=5, GAP_CYC=2, PEND_MAX=3) plus a mid-operation reset sequence.
module tb_pulse_extend_mc;
    localparam int CH   = 4;
    localparam int NCYC = 32;
    localparam int NVEC = 9;

    logic clka  = 1'b0;
    logic rst_n = 1'b0;
    always #5 clka = ~clka;

    pulse_extend_mc_if #(.CH(CH)) bus ();

    pulse_extend_mc #(
        .CH(CH), .EXT_CYC(5), .GAP_CYC(2), .PEND_MAX(3)
    ) dut (
        .clka  (clka),
        .rst_n (rst_n),
        .io    (bus)
    );

    // Bit k of each mask refers to clka edge k of the vector window.
    typedef struct {
        string       name;
        int          ch;
        logic [31:0] ev;
        logic [31:0] rt;
        logic [31:0] exp_out;
        logic [31:0] exp_busy;
        logic [31:0] exp_ovf;
        logic [7:0]  exp_ocnt;
    } vec_t;

    typedef struct {
        logic [CH-1:0] out;
        logic [CH-1:0] busy;
        logic [CH-1:0] ovf;
    } exp_t;

    vec_t vecs[NVEC];
    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input string nm, input int ch, input logic [31:0] ev,
                                input logic [31:0] rt, input logic [31:0] eo,
                                input logic [31:0] eb, input logic [31:0] ef,
                                input logic [7:0] oc);
        vec_t v;
        v.name = nm; v.ch = ch; v.ev = ev; v.rt = rt;
        v.exp_out = eo; v.exp_busy = eb; v.exp_ovf = ef; v.exp_ocnt = oc;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " out"},  32'(bus.signal_outa), 32'h0);
        check({nm, " busy"}, 32'(bus.busy),        32'h0);
        check({nm, " ovf"},  32'(bus.ovf),         32'h0);
    endtask

    initial begin
        vecs[0] = mk("single_ch0",      0, 32'h0000_0001, 32'h0,          32'h0000_003E, 32'h0000_00FE, 32'h0,          8'd0);
        vecs[1] = mk("queue_two",       0, 32'h0000_0005, 32'h0,          32'h0000_1F3E, 32'h0000_7FFE, 32'h0,          8'd0);
        vecs[2] = mk("retrig_merge",    0, 32'h0000_0009, 32'hFFFF_FFFF,  32'h0000_01FE, 32'h0000_07FE, 32'h0,          8'd0);
        vecs[3] = mk("burst_ovf",       0, 32'h0000_001F, 32'h0,          32'h07CF_9F3E, 32'h1FFF_FFFE, 32'hFFFF_FFE0,  8'd1);
        vecs[4] = mk("retrig_lasthigh", 3, 32'h0000_0021, 32'hFFFF_FFFF,  32'h0000_07FE, 32'h0000_1FFE, 32'h0,          8'd0);
        vecs[5] = mk("ev_last_gap",     1, 32'h0000_0081, 32'h0,          32'h0000_1F3E, 32'h0000_7FFE, 32'h0,          8'd0);
        vecs[6] = mk("ev_first_gap",    2, 32'h0000_0041, 32'h0,          32'h0000_1F3E, 32'h0000_7FFE, 32'h0,          8'd0);
        vecs[7] = mk("queue_lasthigh",  2, 32'h0000_0021, 32'h0,          32'h0000_1F3E, 32'h0000_7FFE, 32'h0,          8'd0);
        vecs[8] = mk("retrig_percycle", 0, 32'h0000_000D, 32'h0000_0004,  32'h0000_7CFE, 32'h0001_FFFE, 32'h0,          8'd0);

        bus.pulse_ina = '0;
        bus.retrig    = '0;
        bus.ovf_clr   = 1'b0;

        repeat (2) @(posedge clka);
        #1;
        check_all_zero("reset_state");
        rst_n = 1'b1;
        repeat (2) @(posedge clka);
        #1;
        check_all_zero("post_reset_idle");

        for (int v = 0; v < NVEC; v++) begin
            for (int k = 0; k < NCYC; k++) begin
                exp_t e;
                bus.pulse_ina = vecs[v].ev[k] ? (CH'(1) << vecs[v].ch) : '0;
                bus.retrig    = vecs[v].rt[k] ? (CH'(1) << vecs[v].ch) : '0;
                e.out  = vecs[v].exp_out[k]  ? (CH'(1) << vecs[v].ch) : '0;
                e.busy = vecs[v].exp_busy[k] ? (CH'(1) << vecs[v].ch) : '0;
                e.ovf  = vecs[v].exp_ovf[k]  ? (CH'(1) << vecs[v].ch) : '0;
                sb.push_back(e);
                @(posedge clka);
                #1;
                e = sb.pop_front();
                check($sformatf("%s out c%0d",  vecs[v].name, k), 32'(bus.signal_outa), 32'(e.out));
                check($sformatf("%s busy c%0d", vecs[v].name, k), 32'(bus.busy),        32'(e.busy));
                check($sformatf("%s ovf c%0d",  vecs[v].name, k), 32'(bus.ovf),         32'(e.ovf));
            end
            bus.pulse_ina = '0;
            bus.retrig    = '0;
`ifdef PULSE_EXT_OVF_CNT_EN
            check({vecs[v].name, " ovf_cnt"}, 32'(bus.ovf_cnt[vecs[v].ch*8 +: 8]), 32'(vecs[v].exp_ocnt));
`endif
            bus.ovf_clr = 1'b1;
            @(posedge clka);
            #1;
            bus.ovf_clr = 1'b0;
            @(posedge clka);
            #1;
            check({vecs[v].name, " ovf after clr"}, 32'(bus.ovf), 32'h0);
`ifdef PULSE_EXT_OVF_CNT_EN
            check({vecs[v].name, " ovf_cnt after clr"}, 32'(bus.ovf_cnt), 32'h0);
`endif
        end

        // Reset mid-pulse: outputs must drop asynchronously and stay quiet after release.
        bus.pulse_ina = 4'b0100;
        @(posedge clka);
        #1;
        bus.pulse_ina = '0;
        repeat (3) @(posedge clka);
        #1;
        check("rst_mid pre out", 32'(bus.signal_outa), 32'h4);
        check("rst_mid pre busy", 32'(bus.busy), 32'h4);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid async");
        repeat (2) begin
            @(posedge clka);
            #1;
            check_all_zero("rst_mid held");
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clka);
            #1;
            check_all_zero($sformatf("rst_mid after c%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
